// File: rtl/assoc_tlb_pkg.sv
// Shared types and constants for the associative TLB.
// TLB_WRITE_PROT_EN adds a per-entry writable bit.
package assoc_tlb_pkg;

  localparam int unsigned TLB_DEFAULT_ENTRIES = 8;
  // Entry fields are sized for the widest supported VPN/PPN; unused MSBs stay zero.
  localparam int unsigned TLB_MAX_VPN_W = 52;
  localparam int unsigned TLB_MAX_PPN_W = 52;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_WAIT = 2'd2
  } tlb_state_t;

  typedef struct packed {
    logic                     valid;
    logic [TLB_MAX_VPN_W-1:0] vpn;
    logic [TLB_MAX_PPN_W-1:0] ppn;
`ifdef TLB_WRITE_PROT_EN
    logic                     writable;
`endif
  } tlb_entry_t;

endpackage

// File: rtl/assoc_tlb_victim_sel.sv
// Victim picker: lowest-index invalid entry, else the round-robin pointer.
module tlb_victim_sel #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [ENTRIES-1:0]         valid_i,
  input  logic                       install_i,
  input  logic                       clear_i,
  output logic [$clog2(ENTRIES)-1:0] victim_idx_c_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic             free_found_c;
  logic [IDX_W-1:0] free_idx_c;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;

  // Scan from the top so the lowest free index wins.
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
    end
  end

  assign victim_idx_c_o = free_found_c ? free_idx_c : rr_q;

  // Pointer only moves when a valid entry is actually evicted.
  always_comb begin
    rr_d = rr_q;
    if (clear_i) begin
      rr_d = '0;
    end else if (install_i && !free_found_c) begin
      rr_d = rr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/assoc_tlb.sv
// Fully associative TLB with page-walker miss handling and global flush.
// Optional write protection is enabled with TLB_WRITE_PROT_EN.
module assoc_tlb
  import assoc_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES     = TLB_DEFAULT_ENTRIES,
  parameter int unsigned VA_WIDTH    = 32,
  parameter int unsigned PA_WIDTH    = 32,
  parameter int unsigned PAGE_OFFSET = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [VA_WIDTH-1:0]           req_vaddr_i,
  input  logic                          req_write_i,
  output logic                          resp_valid_o,
  output logic [PA_WIDTH-1:0]           resp_paddr_o,
  output logic                          resp_fault_o,
  output logic                          walk_req_valid_o,
  input  logic                          walk_req_ready_i,
  output logic [VA_WIDTH-PAGE_OFFSET-1:0] walk_vpn_o,
  input  logic                          walk_resp_valid_i,
  input  logic [PA_WIDTH-PAGE_OFFSET-1:0] walk_ppn_i,
  input  logic                          walk_err_i,
  input  logic                          walk_writable_i,
  input  logic                          flush_i
);

  localparam int unsigned VPN_W = VA_WIDTH - PAGE_OFFSET;
  localparam int unsigned PPN_W = PA_WIDTH - PAGE_OFFSET;
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  tlb_state_t             state_q;
  tlb_entry_t             entry_q [ENTRIES];
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic [PA_WIDTH-1:0]    resp_paddr_q;
  logic                   resp_fault_q;
  logic                   walk_req_valid_q;
  logic [VPN_W-1:0]       walk_vpn_q;
  logic [PAGE_OFFSET-1:0] off_q;
  logic                   flush_pend_q;

  logic [VPN_W-1:0]       req_vpn_c;
  logic [PAGE_OFFSET-1:0] req_off_c;
  logic                   hit_c;
  logic [IDX_W-1:0]       hit_idx_c;
  logic [PPN_W-1:0]       hit_ppn_c;
  logic [ENTRIES-1:0]     valid_vec_c;
  logic                   walk_done_c;
  logic                   flush_now_c;
  logic                   install_c;
  logic                   ptr_clear_c;
  logic [IDX_W-1:0]       victim_c;
  logic                   write_fault_c;
  logic                   fill_fault_c;

`ifdef TLB_WRITE_PROT_EN
  logic wr_q;
  assign write_fault_c = req_write_i && !entry_q[hit_idx_c].writable;
  assign fill_fault_c  = wr_q && !walk_writable_i;
`else
  logic unused_wr_c;
  assign unused_wr_c   = ^{req_write_i, walk_writable_i};
  assign write_fault_c = 1'b0;
  assign fill_fault_c  = 1'b0;
`endif

  assign req_vpn_c = req_vaddr_i[VA_WIDTH-1:PAGE_OFFSET];
  assign req_off_c = req_vaddr_i[PAGE_OFFSET-1:0];

  // Parallel VPN compare across all valid entries.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      valid_vec_c[i] = entry_q[i].valid;
      if (entry_q[i].valid && (entry_q[i].vpn == TLB_MAX_VPN_W'(req_vpn_c))) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  assign hit_ppn_c   = PPN_W'(entry_q[hit_idx_c].ppn);
  assign walk_done_c = (state_q == WALK_WAIT) && walk_resp_valid_i;
  assign flush_now_c = flush_pend_q || flush_i;
  assign install_c   = walk_done_c && !walk_err_i && !flush_now_c;
  assign ptr_clear_c = ((state_q == IDLE) && flush_i) || (walk_done_c && flush_now_c);

  tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_vec_c),
    .install_i      (install_c),
    .clear_i        (ptr_clear_c),
    .victim_idx_c_o (victim_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      for (int i = 0; i < int'(ENTRIES); i++) entry_q[i] <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_paddr_q     <= '0;
      resp_fault_q     <= 1'b0;
      walk_req_valid_q <= 1'b0;
      walk_vpn_q       <= '0;
      off_q            <= '0;
      flush_pend_q     <= 1'b0;
`ifdef TLB_WRITE_PROT_EN
      wr_q             <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && hit_c) begin
            resp_valid_q <= 1'b1;
            resp_paddr_q <= {hit_ppn_c, req_off_c};
            resp_fault_q <= write_fault_c;
          end else if (req_valid_i) begin
            walk_vpn_q       <= req_vpn_c;
            off_q            <= req_off_c;
            walk_req_valid_q <= 1'b1;
            req_ready_q      <= 1'b0;
            state_q          <= WALK_REQ;
`ifdef TLB_WRITE_PROT_EN
            wr_q             <= req_write_i;
`endif
          end
          // Lookup above already used the pre-flush contents.
          if (flush_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) entry_q[i].valid <= 1'b0;
          end
        end
        WALK_REQ: begin
          flush_pend_q <= flush_now_c;
          if (walk_req_ready_i) begin
            walk_req_valid_q <= 1'b0;
            state_q          <= WALK_WAIT;
          end
        end
        WALK_WAIT: begin
          flush_pend_q <= flush_now_c;
          if (walk_resp_valid_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_paddr_q <= {walk_ppn_i, off_q};
            resp_fault_q <= walk_err_i || fill_fault_c;
            if (flush_now_c) begin
              for (int i = 0; i < int'(ENTRIES); i++) entry_q[i].valid <= 1'b0;
            end else if (!walk_err_i) begin
              entry_q[victim_c].valid <= 1'b1;
              entry_q[victim_c].vpn   <= TLB_MAX_VPN_W'(walk_vpn_q);
              entry_q[victim_c].ppn   <= TLB_MAX_PPN_W'(walk_ppn_i);
`ifdef TLB_WRITE_PROT_EN
              entry_q[victim_c].writable <= walk_writable_i;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_paddr_o     = resp_paddr_q;
  assign resp_fault_o     = resp_fault_q;
  assign walk_req_valid_o = walk_req_valid_q;
  assign walk_vpn_o       = walk_vpn_q;

endmodule
